// File: rtl/mod_counter_if.sv
// Control and status bundle for mod_counter: the master drives the count
// controls, the slave (the counter) returns the registered count and tc.
interface mod_counter_if #(
  parameter int WIDTH = 5
);
  logic             en;
  logic             up_dn;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             tc;

  modport master (
    output en, up_dn, clr, load, load_val,
    input  out, tc
  );

  modport slave (
    input  en, up_dn, clr, load, load_val,
    output out, tc
  );
endinterface

// File: rtl/mod_counter.sv
// Parametrised modulo up/down counter with prescaler, clear, clamped load and tc pulse.
// Define MOD_COUNTER_SATURATE_EN to saturate at the range limits instead of wrapping.
module mod_counter #(
  parameter int WIDTH    = 5,
  parameter int MODULUS  = 32,
  parameter int PRESCALE = 1
) (
  input logic          clk,
  input logic          reset,
  mod_counter_if.slave bus
);

  localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic             tc_q, tc_d;
  logic             step;
  logic             at_limit;

  assign at_limit = bus.up_dn ? (cnt_q == TOP) : (cnt_q == '0);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    ps_d  = ps_q;
    tc_d  = 1'b0;
    step  = 1'b0;

    if (bus.clr) begin
      cnt_d = '0;
      ps_d  = '0;
    end else if (bus.load) begin
      // int compare keeps the clamp legal when MODULUS fills the whole WIDTH range
      cnt_d = (int'(bus.load_val) >= MODULUS) ? TOP : bus.load_val;
      ps_d  = '0;
    end else if (bus.en) begin
      if (ps_q == PS_LAST) begin
        ps_d = '0;
        step = 1'b1;
      end else begin
        ps_d = ps_q + PS_W'(1);
      end
    end

    if (step) begin
      tc_d = at_limit;
`ifdef MOD_COUNTER_SATURATE_EN
      if (!at_limit) begin
        cnt_d = bus.up_dn ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
      end
`else
      if (at_limit) begin
        cnt_d = bus.up_dn ? '0 : TOP;
      end else begin
        cnt_d = bus.up_dn ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
      end
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      ps_q  <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ps_q  <= ps_d;
      tc_q  <= tc_d;
    end
  end

  assign bus.out = cnt_q;
  assign bus.tc  = tc_q;

endmodule
